// File: rtl/isr_pkg.sv
// Shared constants and pipeline stage record for the multiplier and the
// integer-square-root unit that consumes it.
package isr_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_STAGES = 8;
    // Multiplier bits retired by each stage.
    localparam int STAGE_BITS = XLEN / NUM_STAGES;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] prod;
        logic [XLEN-1:0] mcand_sh;
        logic [XLEN-1:0] mplier_sh;
    } mult_stage_t;

endpackage

// File: rtl/mult_stage.sv
// One registered shift-and-add step: retires K multiplier bits per cycle.
module mult_stage
    import isr_pkg::*;
#(
    parameter int K = STAGE_BITS
) (
    input  logic        clock,
    input  logic        reset,
    input  mult_stage_t stage_in,
    output mult_stage_t stage_out
);

    mult_stage_t     stage_d;
    mult_stage_t     stage_q;
    logic [XLEN-1:0] digit;

    // Accumulate mcand * low K multiplier bits, then realign both operands.
    always_comb begin
        stage_d          = '0;
        digit            = '0;
        digit[K-1:0]     = stage_in.mplier_sh[K-1:0];
        stage_d.valid    = stage_in.valid;
        stage_d.prod     = stage_in.prod + stage_in.mcand_sh * digit;
        stage_d.mcand_sh = stage_in.mcand_sh << K;
        stage_d.mplier_sh = stage_in.mplier_sh >> K;
    end

    // Stage register; data advances every cycle, reset drops in-flight work.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_out = stage_q;

endmodule

// File: rtl/pipe_mult.sv
// Fully pipelined unsigned XLEN x XLEN multiplier, low XLEN bits of product.
// One operand pair accepted per cycle; result after NUM_STAGES cycles.
module pipe_mult
    import isr_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    output logic [XLEN-1:0] product,
    output logic            done
);

    // chain[g] feeds stage g; chain[NUM_STAGES] is the last stage's register.
    mult_stage_t chain [NUM_STAGES+1];

    // Stage 0 sees the raw operands with an empty partial product.
    always_comb begin
        chain[0]           = '0;
        chain[0].valid     = start;
        chain[0].prod      = '0;
        chain[0].mcand_sh  = mcand;
        chain[0].mplier_sh = mplier;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        mult_stage #(
            .K (STAGE_BITS)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .stage_in  (chain[g]),
            .stage_out (chain[g+1])
        );
    end

    assign product = chain[NUM_STAGES].prod;
    assign done    = chain[NUM_STAGES].valid;

endmodule

// File: tb/tb_pipe_mult.sv
// Self-checking bench for pipe_mult: vector table plus hand sequences,
// scoreboard queue carrying expected product and due cycle.
module tb_pipe_mult;
    import isr_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] product;
    logic            done;

    pipe_mult dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .product (product),
        .done    (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] exp;
        int              due;
    } sb_t;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              gap;
    } vec_t;

    sb_t  sbq[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    always @(posedge clock) cyc++;

    // Monitor: every cycle, done must match the scoreboard; product checked when done.
    always @(negedge clock) begin : mon
        logic exp_done;
        sb_t  e;
        if (mon_en) begin
            exp_done = (sbq.size() > 0) && (sbq[0].due == cyc);
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done_timing cyc=%0d got=%b want=%b", cyc, done, exp_done);
            end
            if (exp_done) begin
                e = sbq.pop_front();
                if (done === 1'b1) begin
                    checks++;
                    if (product !== e.exp) begin
                        failures++;
                        $display("FAIL product cyc=%0d got=%h want=%h", cyc, product, e.exp);
                    end
                end
            end
        end
    end

    task automatic issue(input logic s, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        sb_t e;
        @(negedge clock);
        start  = s;
        mcand  = a;
        mplier = b;
        if (s) begin
            e.exp = exp;
            e.due = cyc + NUM_STAGES;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            start  = 1'b0;
            mcand  = {$urandom, $urandom};
            mplier = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sbq.size() > 0 && guard < 4 * NUM_STAGES) begin
            idle(1);
            guard++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d want=0 pending", sbq.size());
            sbq.delete();
        end
        idle(2);
    endtask

    vec_t vecs[6];

    initial begin
        logic [XLEN-1:0] ra, rb, rp;

        vecs[0] = '{64'd5, 64'd7, 64'd35, 10};
        vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 10};
        vecs[2] = '{64'd3, 64'd4, 64'd12, 0};
        vecs[3] = '{64'd0, 64'd123456, 64'd0, 0};
        vecs[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 10};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 10};

        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(negedge clock);
        checks += 2;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        if (product !== '0) begin
            failures++;
            $display("FAIL reset_product got=%h want=0", product);
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        // Table vectors: singles, back-to-back triple, overflow wrap.
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        drain();

        // Start, bubble with changing operands, start.
        issue(1'b1, 64'd10, 64'd10, 64'd100);
        issue(1'b0, 64'hDEAD_BEEF_0000_1234, 64'h1234_5678_9ABC_DEF0, 64'd0);
        issue(1'b1, 64'd12, 64'd12, 64'd144);
        idle(1);
        mcand  = 64'hFFFF_0000_FFFF_0000;
        mplier = 64'h0F0F_0F0F_0F0F_0F0F;
        drain();

        // Four starts, then asynchronous reset mid-cycle: none may complete.
        for (int i = 0; i < 4; i++) issue(1'b1, 64'(i + 2), 64'(i + 3), 64'((i + 2) * (i + 3)));
        @(posedge clock);
        #2;
        reset = 1'b1;
        sbq.delete();
        #1;
        checks += 2;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_done got=%b want=0", done);
        end
        if (product !== '0) begin
            failures++;
            $display("FAIL async_reset_product got=%h want=0", product);
        end
        // Start while reset is held: dropped.
        @(negedge clock);
        start  = 1'b1;
        mcand  = 64'd77;
        mplier = 64'd77;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        idle(12);
        issue(1'b1, 64'd9, 64'd9, 64'd81);
        drain();

        // Random sweep, one pair per cycle.
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rp = ra * rb;
            issue(1'b1, ra, rb, rp);
        end
        drain();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_mult.md
Name: pipe_mult

Overview:
- Fully pipelined unsigned XLEN x XLEN multiplier returning the low XLEN bits of the product.
- Sits directly upstream of the integer-square-root unit, which issues candidate*candidate squarings and compares them against the 64-bit input value.
- Accepts one operand pair per cycle; each result emerges after a fixed latency of NUM_STAGES cycles, flagged by done.

Parameters:
- XLEN, 64, operand and product width in bits.
- NUM_STAGES, 8, number of pipeline stages. Must divide XLEN exactly; each stage consumes XLEN/NUM_STAGES multiplier bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operands valid this cycle; sampled on the rising clock edge.
- mcand  in  XLEN  multiplicand, unsigned.
- mplier  in  XLEN  multiplier, unsigned.
- product  out  XLEN  (mcand*mplier) mod 2^XLEN; registered output.
- done  out  1  product is valid this cycle; high for exactly one cycle per accepted start.

Behaviour:
- Reset (asynchronous, immediate):
  - All stage valid bits, partial products, shifted operands, product and done clear to 0.
  - Any in-flight operation is discarded; no done is produced for it.
- Stage i (0..NUM_STAGES-1) registers the state {valid, prod, mcand_sh, mplier_sh}. With K = XLEN/NUM_STAGES:
  - prod_next = prod + mcand_sh * mplier_sh[K-1:0], truncated to XLEN bits.
  - mcand_sh_next = mcand_sh << K, with zero fill and truncation.
  - mplier_sh_next = mplier_sh >> K.
  - valid_next = valid.
- Stage 0 input: valid=start, prod=0, mcand_sh=mcand, mplier_sh=mplier.
- Output: product and done are the final stage's prod and valid.
- Latency:
  - A start sampled at rising edge N produces done=1 with the correct product after rising edge N+NUM_STAGES-1.
  - With NUM_STAGES=8, done is visible in the 8th cycle after the start cycle.
- Throughput: one operation per cycle.
  - Back-to-back starts yield back-to-back done pulses in issue order.
  - Bubbles (start=0) propagate as done=0 in the corresponding output cycle.
- Data registers advance every cycle regardless of valid.
  - product is don't-care while done=0; the bench must not check it then.
  - Implementation may gate data registers on valid for power, but product must still be correct whenever done=1.
- Operand capture: mcand and mplier are sampled only on the start edge. Later changes to the inputs do not affect in-flight operations.
- Arithmetic:
  - Overflow beyond XLEN bits is silently discarded (wrap-around).
  - No carry or overflow output.
- Reset mid-operation:
  - Asserting reset while operations are in flight clears the pipeline; done stays 0 until a new start completes a full NUM_STAGES traversal after reset deassertion.
  - A start sampled on the same edge reset deasserts is accepted normally.
- No stall or backpressure: the consumer must take product in the cycle done=1.
- Simultaneous reset and start: reset wins; the operation is dropped.

Decomposition:
- Package isr_pkg holds:
  - localparam XLEN=64 and NUM_STAGES=8.
  - typedef struct mult_stage_t {logic valid; logic [XLEN-1:0] prod, mcand_sh, mplier_sh;}.
- The ISR unit imports the same package.
- Sub-module mult_stage: one registered pipeline stage, parameterised by K.
  - Ports: clock, reset, stage_in (mult_stage_t), stage_out (mult_stage_t).
  - pipe_mult instantiates NUM_STAGES copies with a generate loop and chains them.

Test Plan:
- start=1 for one cycle, mcand=5, mplier=7 -> done=1 exactly 8 cycles later with product=35; done=0 in every other cycle.
- mcand=mplier=64'h0000_0000_FFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (largest square the ISR requests).
- Back-to-back starts over three cycles with (3,4), (0,123456), (64'h1_0000_0000, 64'h1_0000_0000) -> three consecutive done pulses with products 12, 0, 0. The third wraps, since 2^64 mod 2^64 = 0.
- Overflow pair 64'hFFFF_FFFF_FFFF_FFFF * 2 -> product=64'hFFFF_FFFF_FFFF_FFFE.
- Pattern start=1,0,1 with operands (10,10), ignored, (12,12) -> done pattern 1,0,1 with products 100, don't-care, 144. Operands changed during the bubble cycle have no effect.
- Issue 4 starts, assert reset asynchronously mid-clock after 3 cycles, deassert -> no done for any of the 4. A fresh start of (9,9) then gives done with 81 after 8 cycles.
- Random sweep: 1000 random {$random,$random} operand pairs issued every cycle -> each done matches the low 64 bits of the reference model's product, checked in order.
